reg_file: RTL and testbench

//  Architectural register file with rename tags for the Tomasulo core. It is the

---
 rtl/reg_file.sv | 71 +++++++
 tb/tb_reg_file.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// reg_file: architectural registers with rename tags, commit write, commit bypass and flush.
module reg_file #(
    parameter int REG_COUNT    = 32,
    parameter int XLEN         = 32,
    parameter int ROB_ID_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    reset_from_rob_bus,
    input  logic                    valid_from_issuer,
    input  logic [4:0]              rd_from_issuer,
    input  logic [ROB_ID_WIDTH-1:0] dest_from_issuer,
    input  logic [4:0]              rs1_from_issuer,
    input  logic [4:0]              rs2_from_issuer,
    output logic [ROB_ID_WIDTH-1:0] qj_to_issuer,
    output logic [XLEN-1:0]         vj_to_issuer,
    output logic [ROB_ID_WIDTH-1:0] qk_to_issuer,
    output logic [XLEN-1:0]         vk_to_issuer,
    input  logic [ROB_ID_WIDTH-1:0] dest_from_rob,
    input  logic [4:0]              rd_from_rob,
    input  logic [XLEN-1:0]         value_from_rob
);
    logic [XLEN-1:0]         value_q [1:REG_COUNT-1];
    logic [XLEN-1:0]         value_d [1:REG_COUNT-1];
    logic [ROB_ID_WIDTH-1:0] tag_q   [1:REG_COUNT-1];
    logic [ROB_ID_WIDTH-1:0] tag_d   [1:REG_COUNT-1];

    always_comb begin
        value_d = value_q;
        tag_d   = tag_q;
        for (int i = 1; i < REG_COUNT; i++) begin
            if (dest_from_rob != '0 && rd_from_rob == 5'(i)) begin
                value_d[i] = value_from_rob;
                // only the matching producer may clear; a younger rename survives
                tag_d[i]   = (tag_q[i] == dest_from_rob) ? '0 : tag_q[i];
            end
            if (reset_from_rob_bus)
                tag_d[i] = '0;
            else if (valid_from_issuer && rd_from_issuer == 5'(i))
                tag_d[i] = dest_from_issuer;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 1; i < REG_COUNT; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else if (rdy) begin
            value_q <= value_d;
            tag_q   <= tag_d;
        end
    end

    function automatic logic [ROB_ID_WIDTH+XLEN-1:0] read_port(input logic [4:0] idx);
        if (idx == '0)
            return '0;
        if (tag_q[idx] == '0)
            return {ROB_ID_WIDTH'(0), value_q[idx]};
        if (dest_from_rob == tag_q[idx] && rd_from_rob == idx)
            return {ROB_ID_WIDTH'(0), value_from_rob};
        return {tag_q[idx], XLEN'(0)};
    endfunction

    always_comb begin
        {qj_to_issuer, vj_to_issuer} = read_port(rs1_from_issuer);
        {qk_to_issuer, vk_to_issuer} = read_port(rs2_from_issuer);
    end
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed scenarios plus randomized traffic against an array-based reference model.
module tb_reg_file;
    logic        clk = 1'b0;
    logic        rst, rdy, reset_from_rob_bus, valid_from_issuer;
    logic [4:0]  rd_from_issuer, rs1_from_issuer, rs2_from_issuer, rd_from_rob;
    logic [4:0]  dest_from_issuer, dest_from_rob;
    logic [4:0]  qj_to_issuer, qk_to_issuer;
    logic [31:0] vj_to_issuer, vk_to_issuer, value_from_rob;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;
    logic [4:0]  m_tag [32];
    logic [31:0] m_val [32];

    reg_file dut (
        .clk(clk), .rst(rst), .rdy(rdy), .reset_from_rob_bus(reset_from_rob_bus),
        .valid_from_issuer(valid_from_issuer), .rd_from_issuer(rd_from_issuer),
        .dest_from_issuer(dest_from_issuer), .rs1_from_issuer(rs1_from_issuer),
        .rs2_from_issuer(rs2_from_issuer), .qj_to_issuer(qj_to_issuer),
        .vj_to_issuer(vj_to_issuer), .qk_to_issuer(qk_to_issuer),
        .vk_to_issuer(vk_to_issuer), .dest_from_rob(dest_from_rob),
        .rd_from_rob(rd_from_rob), .value_from_rob(value_from_rob)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got q=%0d v=%h, expected q=%0d v=%h at %0t",
                     name, act[36:32], act[31:0], exp[36:32], exp[31:0], $time);
        end
    endtask

    function automatic logic [36:0] model_read(input logic [4:0] idx);
        if (idx == 0) return '0;
        if (m_tag[idx] == 0) return {5'd0, m_val[idx]};
        if (dest_from_rob == m_tag[idx] && rd_from_rob == idx) return {5'd0, value_from_rob};
        return {m_tag[idx], 32'd0};
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                m_tag[i] <= '0;
                m_val[i] <= '0;
            end
        end else if (rdy) begin
            if (dest_from_rob != 0 && rd_from_rob != 0) begin
                m_val[rd_from_rob] <= value_from_rob;
                if (m_tag[rd_from_rob] == dest_from_rob) m_tag[rd_from_rob] <= '0;
            end
            if (reset_from_rob_bus)
                for (int i = 0; i < 32; i++) m_tag[i] <= '0;
            else if (valid_from_issuer && rd_from_issuer != 0)
                m_tag[rd_from_issuer] <= dest_from_issuer;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("model_rs1", {qj_to_issuer, vj_to_issuer}, model_read(rs1_from_issuer));
            chk("model_rs2", {qk_to_issuer, vk_to_issuer}, model_read(rs2_from_issuer));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1; rdy = 1; reset_from_rob_bus = 0; valid_from_issuer = 0;
        rd_from_issuer = 0; dest_from_issuer = 0; rs1_from_issuer = 0; rs2_from_issuer = 0;
        dest_from_rob = 0; rd_from_rob = 0; value_from_rob = 0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [4:0] dest);
        valid_from_issuer = 1; rd_from_issuer = rd; dest_from_issuer = dest;
    endtask

    task automatic commit(input logic [4:0] dest, input logic [4:0] rd, input logic [31:0] val);
        dest_from_rob = dest; rd_from_rob = rd; value_from_rob = val;
    endtask

    task automatic rd_chk(input string name, input logic [4:0] r1, input logic [36:0] e1,
                          input logic [4:0] r2, input logic [36:0] e2);
        rs1_from_issuer = r1; rs2_from_issuer = r2;
        #2;
        chk({name, "_j"}, {qj_to_issuer, vj_to_issuer}, e1);
        chk({name, "_k"}, {qk_to_issuer, vk_to_issuer}, e2);
    endtask

    initial begin
        idle();
        rst = 0;
        tick();
        idle();
        check_en = 1;
        rd_chk("reset", 5, '0, 31, '0);
        commit(1, 0, 32'hDEAD);
        tick();
        idle();
        rd_chk("x0", 0, '0, 0, '0);

        issue(5, 3);
        tick();
        idle();
        rd_chk("pending", 5, {5'd3, 32'd0}, 0, '0);
        commit(3, 5, 32'h1234);
        rd_chk("bypass", 5, {5'd0, 32'h1234}, 5, {5'd0, 32'h1234});
        tick();
        idle();
        rd_chk("committed", 5, {5'd0, 32'h1234}, 0, '0);

        issue(7, 2);
        tick();
        issue(7, 4);
        tick();
        idle();
        commit(2, 7, 32'd9);
        rd_chk("young_byp", 7, {5'd4, 32'd0}, 0, '0);
        tick();
        idle();
        rd_chk("young_kept", 7, {5'd4, 32'd0}, 0, '0);

        issue(8, 1);
        tick();
        issue(8, 6);
        commit(1, 8, 32'h55);
        tick();
        idle();
        rd_chk("issue_wins", 8, {5'd6, 32'd0}, 0, '0);

        issue(3, 5);
        tick();
        issue(4, 6);
        tick();
        idle();
        rd_chk("pre_flush", 3, {5'd5, 32'd0}, 4, {5'd6, 32'd0});
        reset_from_rob_bus = 1;
        commit(5, 3, 32'h80);
        issue(9, 7);
        tick();
        idle();
        rd_chk("flush34", 3, {5'd0, 32'h80}, 4, '0);
        rd_chk("flush9_8", 9, '0, 8, {5'd0, 32'h55});
        rd_chk("flush7_5", 7, {5'd0, 32'd9}, 5, {5'd0, 32'h1234});

        rdy = 0;
        issue(10, 3);
        commit(1, 10, 32'hAA);
        tick();
        idle();
        rd_chk("hold", 10, '0, 3, {5'd0, 32'h80});
        issue(11, 2);
        tick();
        idle();
        rd_chk("pre_rst", 11, {5'd2, 32'd0}, 0, '0);
        rst = 0;
        tick();
        idle();
        rd_chk("mid_rst", 11, '0, 3, '0);

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(199) != 0);
            rdy = ($urandom_range(9) != 0);
            reset_from_rob_bus = ($urandom_range(19) == 0);
            valid_from_issuer = $urandom_range(1);
            rd_from_issuer = 5'($urandom_range(7));
            dest_from_issuer = 5'($urandom_range(31, 1));
            rs1_from_issuer = 5'($urandom_range(7));
            rs2_from_issuer = 5'($urandom_range(7));
            rd_from_rob = 5'($urandom_range(7));
            dest_from_rob = ($urandom_range(2) == 0) ? 5'($urandom_range(31)) : m_tag[rd_from_rob];
            value_from_rob = $urandom;
            tick();
        end
        idle();
        tick();
        check_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
